rtype_imem_loader: RTL and testbench
====================================

Name: rtype_imem_loader

Overview:
Program loader that writes R-type add/sub/and/or instructions into the CPU's instruction memory. It is the writer for the instruction memory that the CPU fetch stage reads.
- Accepts decoded fields over a valid/ready stream and encodes each into a 32-bit MIPS R-type word.
- Buffers encoded words in a small FIFO and writes them to sequential word addresses from a base.
- Reports completion, word count and overflow.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
IMEM_WORDS, 1024, instruction memory size in words
ADDR_W, 10, word-address width (log2 IMEM_WORDS)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  begin load session; honoured only in IDLE
base_addr  in  32  byte address of first instruction; bits [1:0] ignored
in_valid  in  1  instruction fields valid
in_ready  out  1  loader accepts this cycle
in_func  in  2  00 add, 01 sub, 10 and, 11 or
in_rs / in_rt / in_rd  in  5 each  register fields
in_last  in  1  marks final instruction of session
imem_busy  in  1  memory cannot take a write this cycle
imem_we  out  1  one-cycle write strobe
imem_addr  out  ADDR_W  word index
imem_wdata  out  32  encoded instruction
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
count  out  ADDR_W+1  words written this session
err_overflow  out  1  sticky; set when a word is dropped past end of memory

Behaviour:
- Reset (sync, active-high): state IDLE; FIFO emptied; write pointer 0. All outputs 0: in_ready, imem_we, imem_addr, imem_wdata, busy, done, count, err_overflow. Reset mid-session aborts with no further writes, and imem_we is 0 from the next cycle.
- Encoding: {6'b000000, rs, rt, rd, 5'b00000, funct}.
  - funct: add 6'h20, sub 6'h22, and 6'h24, or 6'h25.
  - The encode happens at push; the FIFO stores the 32-bit word.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - On start: go to LOAD; wptr <= base_addr[ADDR_W+1:2] zero-extended to ADDR_W+1 bits; count <= 0; err_overflow <= 0.
- LOAD:
  - in_ready = !fifo_full. It is registered-independent of same-cycle pop; full means no accept even if a pop occurs.
  - Push on in_valid & in_ready.
  - If the accepted beat has in_last=1, go to DRAIN; in_ready=0 from the next cycle.
- Writer, active in LOAD and DRAIN:
  - A pop occurs when the FIFO is non-empty and imem_busy=0.
  - If wptr < IMEM_WORDS: at that edge imem_we<=1, imem_addr<=wptr[ADDR_W-1:0], imem_wdata<=word. Then wptr++ and count++.
  - If wptr >= IMEM_WORDS: the word is discarded, imem_we<=0, err_overflow<=1. The pointer does not wrap.
  - imem_we is 0 on every cycle without a pop. imem_addr/imem_wdata hold their last values.
- Latency: a word pushed at edge N is written with imem_we high in the cycle after edge N+1 at the earliest. Throughput is 1 word/cycle when imem_busy stays low.
- Simultaneous push and pop in the same cycle is allowed; occupancy is unchanged.
- DRAIN: when the FIFO is empty and no pop occurs this cycle, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. count and err_overflow hold until the next start or reset.
- start outside IDLE is ignored. in_valid outside LOAD is ignored; no push.

Test Plan:
1. Reset, then start with base_addr=0. Push add/sub/and/or, each rs=7 rt=1 rd=3, last on the 4th, imem_busy=0.
   - Writes at addr 0..3: 32'h00E11820, 00E11822, 00E11824, 00E11825, on consecutive cycles.
   - Then done pulses once; count=4; busy drops.
2. base_addr=32'h10, one add rs=2 rt=4 rd=5 with last.
   - Single write addr 4, data 32'h00442820; count=1.
3. imem_busy held high for 8 cycles while 6 instructions are offered back-to-back.
   - Exactly 4 accepted; in_ready=0 while full.
   - After release, all 6 are written to addr 0..5 in order; no loss or duplication.
4. base_addr=32'hFF8, push 3 instructions.
   - Writes at 1022 and 1023 only; third dropped; err_overflow=1; count=2; done still pulses.
5. Reset asserted in LOAD with 2 words in FIFO.
   - Next cycle: imem_we=0, all outputs 0, in_ready=0.
   - A later start begins a clean session; no stale words are written.
6. start pulsed while busy.
   - Ignored: wptr and count are unchanged, and the session completes normally.

Source files
------------

// File: rtl/rtype_imem_loader.sv
// rtype_imem_loader: encodes add/sub/and/or R-type instructions from a field
// stream and writes them through a small FIFO into sequential imem words.
module rtype_imem_loader #(
  parameter int DEPTH      = 4,
  parameter int IMEM_WORDS = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_func,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic              in_last,
  input  logic              imem_busy,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_overflow
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] IMEM_LIMIT = IMEM_WORDS[ADDR_W:0];

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic [31:0] encode_rtype(
    input logic [1:0] func,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd
  );
    logic [5:0] funct;
    case (func)
      2'b00:   funct = 6'h20;
      2'b01:   funct = 6'h22;
      2'b10:   funct = 6'h24;
      2'b11:   funct = 6'h25;
      default: funct = 6'h20;
    endcase
    return {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [31:0]      fifo_mem_r [DEPTH];
  logic [PTR_W:0]   fifo_wr_r;
  logic [PTR_W:0]   fifo_rd_r;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic             push_s;
  logic             pop_s;
  logic             writer_on_s;
  logic             in_range_s;
  logic             start_ok_s;
  logic [ADDR_W:0]  wptr_r;
  logic             unused_base_s;

  assign unused_base_s = ^{base_addr[31:ADDR_W+2], base_addr[1:0]};

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty_s = (fifo_wr_r == fifo_rd_r);
  assign fifo_full_s  = (fifo_wr_r[PTR_W] != fifo_rd_r[PTR_W]) &&
                        (fifo_wr_r[PTR_W-1:0] == fifo_rd_r[PTR_W-1:0]);

  assign in_ready    = (state_r == S_LOAD) && !fifo_full_s;
  assign push_s      = in_ready && in_valid;
  assign writer_on_s = (state_r == S_LOAD) || (state_r == S_DRAIN);
  assign pop_s       = writer_on_s && !fifo_empty_s && !imem_busy;
  assign in_range_s  = (wptr_r < IMEM_LIMIT);
  assign start_ok_s  = (state_r == S_IDLE) && start;

  assign busy = (state_r != S_IDLE);
  assign done = (state_r == S_DONE);

  // Session sequencing: load until the last beat, drain the FIFO, then pulse done.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_LOAD;
        else       state_nxt_s = S_IDLE;
      end
      S_LOAD: begin
        if (push_s && in_last) state_nxt_s = S_DRAIN;
        else                   state_nxt_s = S_LOAD;
      end
      S_DRAIN: begin
        if (fifo_empty_s && !pop_s) state_nxt_s = S_DONE;
        else                        state_nxt_s = S_DRAIN;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_nxt_s;
  end

  // FIFO pointers; a fresh session always starts from an empty FIFO.
  always_ff @(posedge clock) begin
    if (reset || start_ok_s) begin
      fifo_wr_r <= '0;
      fifo_rd_r <= '0;
    end else begin
      if (push_s) fifo_wr_r <= fifo_wr_r + 1'b1;
      if (pop_s)  fifo_rd_r <= fifo_rd_r + 1'b1;
    end
  end

  // FIFO storage holds already-encoded words; contents need no reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem_r[fifo_wr_r[PTR_W-1:0]] <= encode_rtype(in_func, in_rs, in_rt, in_rd);
    end
  end

  // Writer: words past the end of memory are dropped and flagged, the pointer never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_r       <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'h0000_0000;
    end else if (start_ok_s) begin
      wptr_r       <= {1'b0, base_addr[ADDR_W+1:2]};
      count        <= '0;
      err_overflow <= 1'b0;
      imem_we      <= 1'b0;
    end else if (pop_s) begin
      if (in_range_s) begin
        imem_we    <= 1'b1;
        imem_addr  <= wptr_r[ADDR_W-1:0];
        imem_wdata <= fifo_mem_r[fifo_rd_r[PTR_W-1:0]];
        wptr_r     <= wptr_r + 1'b1;
        count      <= count + 1'b1;
      end else begin
        imem_we      <= 1'b0;
        err_overflow <= 1'b1;
      end
    end else begin
      imem_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rtype_imem_loader.sv
// Self-checking bench for rtype_imem_loader: directed plan scenarios plus
// randomized sessions checked against a list-level model of the writes.
module tb_rtype_imem_loader;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0] func;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  logic        clock = 1'b0;
  logic        reset, start, in_valid, in_last, imem_busy;
  logic [31:0] base_addr;
  logic [1:0]  in_func;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_ready, imem_we, busy, done, err_overflow;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_busy = 0;
  int rdy_full = 0;

  instr_t      items[$];
  logic [9:0]  obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_count;
  bit          exp_err;

  rtype_imem_loader #(.DEPTH(DEPTH), .IMEM_WORDS(1024), .ADDR_W(10)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_last(in_last),
    .imem_busy(imem_busy), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .count(count),
    .err_overflow(err_overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      obs_addr.push_back(imem_addr);
      obs_data.push_back(imem_wdata);
      obs_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cnt++;
  end

  // Instruction word from its fields by plain arithmetic on field positions.
  function automatic logic [31:0] ref_word(instr_t it);
    int fn;
    case (it.func)
      2'd0:    fn = 32;
      2'd1:    fn = 34;
      2'd2:    fn = 36;
      default: fn = 37;
    endcase
    return 32'(int'(it.rs) * 2097152 + int'(it.rt) * 65536 + int'(it.rd) * 2048 + fn);
  endfunction

  function automatic void build_expect(input logic [31:0] base);
    int a;
    exp_addr.delete();
    exp_data.delete();
    exp_err = 1'b0;
    a = int'((base >> 2) & 32'd1023);
    for (int i = 0; i < items.size(); i++) begin
      if (a + i < 1024) begin
        exp_addr.push_back(10'(a + i));
        exp_data.push_back(ref_word(items[i]));
      end else begin
        exp_err = 1'b1;
      end
    end
    exp_count = exp_addr.size();
  endfunction

  function automatic void gen_items(input int n);
    instr_t it;
    items.delete();
    for (int i = 0; i < n; i++) begin
      it.func = 2'($urandom_range(0, 3));
      it.rs   = 5'($urandom_range(0, 31));
      it.rt   = 5'($urandom_range(0, 31));
      it.rd   = 5'($urandom_range(0, 31));
      items.push_back(it);
    end
  endfunction

  task automatic drive_session(input logic [31:0] base, input int busy_hold,
                               input bit rand_busy, input bit gaps, input int glitch_at);
    int idx, hold, guard;
    bit rdy;
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    done_cnt = 0; acc_busy = 0; rdy_full = 0;
    hold = busy_hold;
    @(negedge clock);
    start = 1'b1; base_addr = base;
    @(negedge clock);
    start = 1'b0; base_addr = $urandom;
    idx = 0; guard = 0;
    while (idx < items.size() && guard < 500) begin
      if (hold > 0) begin imem_busy = 1'b1; hold--; end
      else imem_busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
      start = (guard == glitch_at);
      if (start) base_addr = 32'h0000_0200;
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_func = items[idx].func; in_rs = items[idx].rs;
      in_rt = items[idx].rt; in_rd = items[idx].rd;
      in_last = (idx == items.size() - 1);
      rdy = in_ready;
      if (imem_busy && acc_busy >= DEPTH && rdy) rdy_full++;
      if (imem_busy && rdy && in_valid) acc_busy++;
      @(posedge clock);
      if (rdy && in_valid) idx++;
      @(negedge clock);
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    while (done_cnt == 0 && guard < 1000) begin
      if (hold > 0) begin imem_busy = 1'b1; hold--; end
      else imem_busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(negedge clock);
      guard++;
    end
    imem_busy = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_func = '0; in_rs = '0; in_rt = '0; in_rd = '0; imem_busy = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({in_ready, imem_we, busy, done, err_overflow} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 00000", {in_ready, imem_we, busy, done, err_overflow});
    end
    checks++;
    if ({imem_addr, imem_wdata, count} !== 53'd0) begin
      failures++; $display("FAIL reset_buses: got %0h/%0h/%0d expected 0/0/0", imem_addr, imem_wdata, count);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    instr_t it;
    items.delete();
    for (int f = 0; f < 4; f++) begin
      it.func = 2'(f); it.rs = 5'd7; it.rt = 5'd1; it.rd = 5'd3;
      items.push_back(it);
    end
    exp_addr = '{10'd0, 10'd1, 10'd2, 10'd3};
    exp_data = '{32'h00E11820, 32'h00E11822, 32'h00E11824, 32'h00E11825};
    drive_session(32'h0, 0, 1'b0, 1'b0, -1);
    checks++;
    if (obs_addr.size() !== exp_addr.size()) begin
      failures++; $display("FAIL basic_nwrites: got %0d expected %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        failures++; $display("FAIL basic_write%0d: got %0d/%08h expected %0d/%08h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
      checks++;
      if (obs_cyc[i] - obs_cyc[0] !== i) begin
        failures++; $display("FAIL basic_back_to_back%0d: got offset %0d expected %0d", i, obs_cyc[i] - obs_cyc[0], i);
      end
    end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt); end
    checks++;
    if (count !== 11'd4) begin failures++; $display("FAIL basic_count: got %0d expected 4", count); end
    checks++;
    if ({busy, in_ready, err_overflow} !== 3'b000) begin
      failures++; $display("FAIL basic_idle: got %b expected 000", {busy, in_ready, err_overflow});
    end
  endtask

  task automatic test_base_offset();
    instr_t it;
    it.func = 2'd0; it.rs = 5'd2; it.rt = 5'd4; it.rd = 5'd5;
    items.delete(); items.push_back(it);
    drive_session(32'h10, 0, 1'b0, 1'b0, -1);
    checks++;
    if (obs_addr.size() !== 1) begin
      failures++; $display("FAIL offset_nwrites: got %0d expected 1", obs_addr.size());
    end else begin
      checks++;
      if (obs_addr[0] !== 10'd4 || obs_data[0] !== 32'h00442820) begin
        failures++; $display("FAIL offset_write: got %0d/%08h expected 4/00442820", obs_addr[0], obs_data[0]);
      end
    end
    checks++;
    if (count !== 11'd1) begin failures++; $display("FAIL offset_count: got %0d expected 1", count); end
  endtask

  task automatic test_backpressure();
    gen_items(6);
    build_expect(32'h0);
    drive_session(32'h0, 8, 1'b0, 1'b0, -1);
    checks++;
    if (acc_busy !== DEPTH) begin failures++; $display("FAIL bp_accepted: got %0d expected %0d", acc_busy, DEPTH); end
    checks++;
    if (rdy_full !== 0) begin failures++; $display("FAIL bp_ready_full: got %0d ready cycles expected 0", rdy_full); end
    checks++;
    if (obs_addr.size() !== exp_addr.size()) begin
      failures++; $display("FAIL bp_nwrites: got %0d expected %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        failures++; $display("FAIL bp_write%0d: got %0d/%08h expected %0d/%08h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (count !== 11'd6) begin failures++; $display("FAIL bp_count: got %0d expected 6", count); end
  endtask

  task automatic test_overflow();
    gen_items(3);
    build_expect(32'hFF8);
    drive_session(32'hFF8, 0, 1'b0, 1'b0, -1);
    checks++;
    if (obs_addr.size() !== 2) begin
      failures++; $display("FAIL ovf_nwrites: got %0d expected 2", obs_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        failures++; $display("FAIL ovf_write%0d: got %0d/%08h expected %0d/%08h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_err: got %b expected 1", err_overflow); end
    checks++;
    if (count !== 11'd2) begin failures++; $display("FAIL ovf_count: got %0d expected 2", count); end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL ovf_done: got %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    gen_items(2);
    @(negedge clock);
    start = 1'b1; base_addr = 32'h40; imem_busy = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_last = 1'b0;
      in_func = items[i].func; in_rs = items[i].rs; in_rt = items[i].rt; in_rd = items[i].rd;
      @(negedge clock);
    end
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midrst_loading: got busy=%b expected 1", busy); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({in_ready, imem_we, busy, done, err_overflow} !== 5'b0) begin
      failures++; $display("FAIL midrst_flags: got %b expected 00000", {in_ready, imem_we, busy, done, err_overflow});
    end
    checks++;
    if ({imem_addr, imem_wdata, count} !== 53'd0) begin
      failures++; $display("FAIL midrst_buses: got %0h/%0h/%0d expected 0/0/0", imem_addr, imem_wdata, count);
    end
    reset = 1'b0; imem_busy = 1'b0;
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    repeat (10) @(negedge clock);
    checks++;
    if (obs_addr.size() !== 0) begin failures++; $display("FAIL midrst_stale: got %0d writes expected 0", obs_addr.size()); end
    gen_items(3);
    build_expect(32'h80);
    drive_session(32'h80, 0, 1'b0, 1'b0, -1);
    checks++;
    if (obs_addr.size() !== exp_addr.size()) begin
      failures++; $display("FAIL midrst_nwrites: got %0d expected %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        failures++; $display("FAIL midrst_write%0d: got %0d/%08h expected %0d/%08h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    gen_items(5);
    build_expect(32'h40);
    drive_session(32'h40, 0, 1'b0, 1'b0, 2);
    checks++;
    if (obs_addr.size() !== exp_addr.size()) begin
      failures++; $display("FAIL restart_nwrites: got %0d expected %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        failures++; $display("FAIL restart_write%0d: got %0d/%08h expected %0d/%08h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (count !== 11'd5 || done_cnt !== 1) begin
      failures++; $display("FAIL restart_count: got count=%0d done=%0d expected 5/1", count, done_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] base;
    for (int s = 0; s < 8; s++) begin
      gen_items($urandom_range(1, 8));
      if (s % 2 == 1) base = 32'($urandom_range(1016, 1023)) << 2;
      else            base = 32'($urandom_range(0, 1023)) << 2;
      base = base | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 15)) << 12);
      build_expect(base);
      drive_session(base, $urandom_range(0, 5), s >= 2, s % 2 == 0, -1);
      checks++;
      if (obs_addr.size() !== exp_addr.size()) begin
        failures++; $display("FAIL rand%0d_nwrites: got %0d expected %0d", s, obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
        checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          failures++; $display("FAIL rand%0d_write%0d: got %0d/%08h expected %0d/%08h", s, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        end
      end
      checks++;
      if (count !== 11'(exp_count) || err_overflow !== exp_err || done_cnt !== 1) begin
        failures++; $display("FAIL rand%0d_status: got count=%0d err=%b done=%0d expected %0d/%b/1", s, count, err_overflow, done_cnt, exp_count, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_base_offset();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
